weight_loader_m_axi_fifo: RTL and testbench

Parameterised first-word-fall-through FIFO for the weight-loader m_axi read path. It buffers burst beats between the AXI read-data channel and the dequantisation stage. Storage is a registered-read dual-port RAM of DEPTH-1 words plus one output register, giving DEPTH words of total capacity. It adds occupancy count, almost-full/almost-empty flags and a global clock-enable stall on top of the plain RAM.

---
 rtl/weight_loader_m_axi_fifo_if.sv | 26 ++
 rtl/weight_loader_m_axi_fifo.sv | 94 +++++++++
 tb/tb_weight_loader_m_axi_fifo.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/weight_loader_m_axi_fifo_if.sv
// Push/pop handshake, occupancy and threshold flags of the weight-loader read-path FIFO.
// The FIFO binds to the slave modport; the producer/consumer side uses master.
interface weight_loader_m_axi_fifo_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 6
);
  logic                  if_write;
  logic [DATA_WIDTH-1:0] if_din;
  logic                  if_full_n;
  logic                  if_read;
  logic [DATA_WIDTH-1:0] if_dout;
  logic                  if_empty_n;
  logic [ADDR_WIDTH:0]   count;
  logic                  almost_full;
  logic                  almost_empty;

  modport master (
    output if_write, if_din, if_read,
    input  if_full_n, if_dout, if_empty_n, count, almost_full, almost_empty
  );

  modport slave (
    input  if_write, if_din, if_read,
    output if_full_n, if_dout, if_empty_n, count, almost_full, almost_empty
  );
endinterface

// File: rtl/weight_loader_m_axi_fifo.sv
// FWFT FIFO: DEPTH-1 word registered-read RAM, one prefetch stage, one output register; push->head in 2 edges.
// Backpressure via registered if_full_n; clk_en=0 freezes every register and suppresses RAM writes.
module weight_loader_m_axi_fifo #(
  parameter     MEM_STYLE     = "auto",
  parameter int DATA_WIDTH    = 32,
  parameter int ADDR_WIDTH    = 6,
  parameter int DEPTH         = 64,
  parameter int AFULL_THRESH  = DEPTH - 4,
  parameter int AEMPTY_THRESH = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic clk_en,
  weight_loader_m_axi_fifo_if.slave bus
);
  localparam int CW        = ADDR_WIDTH + 1;
  localparam int RAM_WORDS = DEPTH - 1;

  localparam logic [ADDR_WIDTH-1:0] PTR_LAST = ADDR_WIDTH'(RAM_WORDS - 1);
  localparam logic [CW-1:0]         DEPTH_C  = CW'(DEPTH);
  localparam logic [CW-1:0]         AFULL_C  = CW'(AFULL_THRESH);
  localparam logic [CW-1:0]         AEMPTY_C = CW'(AEMPTY_THRESH);

  (* ram_style = MEM_STYLE *) logic [DATA_WIDTH-1:0] mem [0:RAM_WORDS-1];

  logic [ADDR_WIDTH-1:0] wptr, rptr;
  logic [CW-1:0]         count_q, count_next, ram_cnt;
  logic [DATA_WIDTH-1:0] q_dat, out_dat;
  logic                  q_vld, out_vld;
  logic                  full_n_q, afull_q, aempty_q;
  logic                  push, pop, load_out, issue;

  function automatic logic [ADDR_WIDTH-1:0] ptr_inc(input logic [ADDR_WIDTH-1:0] p);
    return (p == PTR_LAST) ? '0 : p + ADDR_WIDTH'(1);
  endfunction

  assign push = clk_en & bus.if_write & full_n_q;
  assign pop  = clk_en & bus.if_read & out_vld;

  // Words still sitting in RAM = total occupancy minus prefetch stage and output register.
  assign ram_cnt  = count_q - CW'(q_vld) - CW'(out_vld);
  assign load_out = q_vld & (~out_vld | pop);
  assign issue    = (ram_cnt != '0) & (~q_vld | load_out);

  always_comb begin
    count_next = count_q;
    if (push && !pop)
      count_next = count_q + CW'(1);
    else if (pop && !push)
      count_next = count_q - CW'(1);
  end

  // Storage kept free of reset so it maps onto block RAM; a stale q_dat is harmless once q_vld clears.
  always_ff @(posedge clk) begin
    if (push)
      mem[wptr] <= bus.if_din;
    if (clk_en && issue)
      q_dat <= mem[rptr];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wptr     <= '0;
      rptr     <= '0;
      q_vld    <= 1'b0;
      out_vld  <= 1'b0;
      out_dat  <= '0;
      count_q  <= '0;
      full_n_q <= 1'b1;
      afull_q  <= 1'b0;
      aempty_q <= 1'b1;
    end else if (clk_en) begin
      if (push)
        wptr <= ptr_inc(wptr);
      if (issue)
        rptr <= ptr_inc(rptr);
      q_vld   <= issue | (q_vld & ~load_out);
      out_vld <= load_out | (out_vld & ~pop);
      if (load_out)
        out_dat <= q_dat;
      count_q  <= count_next;
      full_n_q <= (count_next < DEPTH_C);
      afull_q  <= (count_next >= AFULL_C);
      aempty_q <= (count_next <= AEMPTY_C);
    end
  end

  assign bus.if_dout      = out_dat;
  assign bus.if_empty_n   = out_vld;
  assign bus.if_full_n    = full_n_q;
  assign bus.count        = count_q;
  assign bus.almost_full  = afull_q;
  assign bus.almost_empty = aempty_q;
endmodule

// File: tb/tb_weight_loader_m_axi_fifo.sv
// Directed + random bench for weight_loader_m_axi_fifo with an in-order scoreboard queue.
module tb_weight_loader_m_axi_fifo;
  localparam int DW     = 32;
  localparam int AW     = 6;
  localparam int DEPTH  = 64;
  localparam int AFULL  = DEPTH - 4;
  localparam int AEMPTY = 2;

  logic clk = 1'b0;
  logic reset;
  logic clk_en;

  int checks   = 0;
  int failures = 0;
  int mcount   = 0;
  logic [DW-1:0] exp_q[$];

  weight_loader_m_axi_fifo_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  weight_loader_m_axi_fifo #(
    .MEM_STYLE("auto"), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH),
    .AFULL_THRESH(AFULL), .AEMPTY_THRESH(AEMPTY)
  ) dut (
    .clk(clk), .reset(reset), .clk_en(clk_en), .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs, predict acceptance from the visible handshake, then verify after the edge.
  task automatic cycle(input logic en, input logic wr, input logic rd, input logic [DW-1:0] din);
    logic          push_ok, pop_ok;
    logic [DW-1:0] pre_dout, exp_word;
    logic          pre_empty_n;
    clk_en       = en;
    bus.if_write = wr;
    bus.if_read  = rd;
    bus.if_din   = din;
    push_ok      = en & wr & bus.if_full_n;
    pop_ok       = en & rd & bus.if_empty_n;
    pre_dout     = bus.if_dout;
    pre_empty_n  = bus.if_empty_n;
    if (pop_ok) begin
      chk("pop_has_expected", 32'(exp_q.size() != 0), 1);
      if (exp_q.size() != 0) begin
        exp_word = exp_q.pop_front();
        chk("pop_data", pre_dout, exp_word);
      end
    end
    if (push_ok)
      exp_q.push_back(din);
    if (push_ok && !pop_ok)
      mcount++;
    else if (pop_ok && !push_ok)
      mcount--;
    @(posedge clk);
    #1;
    chk("count", 32'(bus.count), mcount);
    chk("full_n", 32'(bus.if_full_n), 32'(mcount < DEPTH));
    chk("almost_full", 32'(bus.almost_full), 32'(mcount >= AFULL));
    chk("almost_empty", 32'(bus.almost_empty), 32'(mcount <= AEMPTY));
    if (!en) begin
      chk("frozen_dout", bus.if_dout, pre_dout);
      chk("frozen_empty_n", 32'(bus.if_empty_n), 32'(pre_empty_n));
    end
  endtask

  task automatic do_reset(input logic en);
    reset        = 1'b1;
    clk_en       = en;
    bus.if_write = 1'b0;
    bus.if_read  = 1'b0;
    bus.if_din   = '0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    exp_q.delete();
    mcount = 0;
    chk("rst_count", 32'(bus.count), 0);
    chk("rst_empty_n", 32'(bus.if_empty_n), 0);
    chk("rst_full_n", 32'(bus.if_full_n), 1);
    chk("rst_dout", bus.if_dout, 0);
    chk("rst_almost_empty", 32'(bus.almost_empty), 1);
    chk("rst_almost_full", 32'(bus.almost_full), 0);
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      cycle(1'b1, 1'b0, 1'b1, '0);
      n++;
    end
    chk("drain_budget", 32'(exp_q.size()), 0);
    repeat (3) cycle(1'b1, 1'b0, 1'b0, '0);
    chk("drain_empty_n", 32'(bus.if_empty_n), 0);
  endtask

  initial begin
    logic en, wr, rd;

    // Reset then idle
    do_reset(1'b1);
    for (int i = 0; i < 10; i++) begin
      cycle(1'b1, 1'b0, 1'b0, '0);
      chk("idle_empty_n", 32'(bus.if_empty_n), 0);
      chk("idle_dout", bus.if_dout, 0);
    end

    // Single push: head appears after the second edge following the push
    cycle(1'b1, 1'b1, 1'b0, 32'hA5A5_0001);
    chk("lat_n0_empty_n", 32'(bus.if_empty_n), 0);
    cycle(1'b1, 1'b0, 1'b0, '0);
    chk("lat_n1_empty_n", 32'(bus.if_empty_n), 0);
    cycle(1'b1, 1'b0, 1'b0, '0);
    chk("lat_n2_empty_n", 32'(bus.if_empty_n), 1);
    chk("lat_n2_dout", bus.if_dout, 32'hA5A5_0001);
    chk("lat_n2_count", 32'(bus.count), 1);
    cycle(1'b1, 1'b0, 1'b1, '0);
    chk("single_pop_empty_n", 32'(bus.if_empty_n), 0);
    chk("single_pop_count", 32'(bus.count), 0);

    // Fill to capacity, overflow push, push+pop at full, drain without bubbles
    for (int i = 0; i < DEPTH; i++) begin
      cycle(1'b1, 1'b1, 1'b0, 32'(i));
      if (i == AFULL - 2) chk("af_below_thresh", 32'(bus.almost_full), 0);
      if (i == AFULL - 1) chk("af_at_thresh", 32'(bus.almost_full), 1);
    end
    chk("fill_full_n", 32'(bus.if_full_n), 0);
    cycle(1'b1, 1'b1, 1'b0, 32'hDEAD_BEEF);
    chk("overflow_count", 32'(bus.count), DEPTH);
    chk("full_head", bus.if_dout, 0);
    cycle(1'b1, 1'b1, 1'b1, 32'hBAD0_0001);
    chk("full_pushpop_count", 32'(bus.count), DEPTH - 1);
    chk("full_pushpop_full_n", 32'(bus.if_full_n), 1);
    for (int i = 1; i < DEPTH; i++) begin
      chk("drain_nobubble", 32'(bus.if_empty_n), 1);
      chk("drain_order", bus.if_dout, 32'(i));
      cycle(1'b1, 1'b0, 1'b1, '0);
    end
    chk("drained_empty_n", 32'(bus.if_empty_n), 0);
    chk("drained_count", 32'(bus.count), 0);

    // Full-rate streaming: steady at three words, one pop per edge
    for (int i = 0; i < 500; i++) begin
      if (i >= 3) begin
        chk("stream_nobubble", 32'(bus.if_empty_n), 1);
        chk("stream_count", 32'(bus.count), 3);
      end
      cycle(1'b1, 1'b1, 1'b1, $urandom);
    end
    drain(20);

    // Mixed traffic with clk_en low about 30% of cycles
    for (int i = 0; i < 600; i++) begin
      en = ($urandom_range(0, 99) >= 30);
      wr = ($urandom_range(0, 99) < 55);
      rd = ($urandom_range(0, 99) < 50);
      cycle(en, wr, rd, $urandom);
    end
    drain(200);

    // Reset with 37 words stored discards them
    for (int i = 0; i < 37; i++)
      cycle(1'b1, 1'b1, 1'b0, 32'h5000_0000 + 32'(i));
    cycle(1'b1, 1'b0, 1'b0, '0);
    chk("pre_reset_count", 32'(bus.count), 37);
    do_reset(1'b0);
    cycle(1'b1, 1'b1, 1'b0, 32'h0000_1234);
    cycle(1'b1, 1'b0, 1'b0, '0);
    cycle(1'b1, 1'b0, 1'b0, '0);
    chk("post_reset_head", bus.if_dout, 32'h0000_1234);
    chk("post_reset_empty_n", 32'(bus.if_empty_n), 1);
    drain(10);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end
endmodule
